// File: rtl/trap_sequencer_if.sv
// Trap sequencer request, CSR-file and redirect signals bundled into one port.
interface trap_sequencer_if #(
  parameter int MXLEN   = 64,
  parameter int NUM_INT = 14
);
  logic               exc_valid_i;
  logic               exc_ready_o;
  logic [5:0]         exc_cause_i;
  logic [MXLEN-1:0]   exc_pc_i;
  logic [MXLEN-1:0]   exc_tval_i;
  logic               mret_valid_i;
  logic [NUM_INT-1:0] int_pending_i;
  logic [MXLEN-1:0]   int_pc_i;
  logic [MXLEN-1:0]   mstatus_i;
  logic [MXLEN-1:0]   mtvec_i;
  logic [MXLEN-1:0]   mepc_i;
  logic               csr_we_o;
  logic [11:0]        csr_addr_o;
  logic [MXLEN-1:0]   csr_wdata_o;
  logic               flush_o;
  logic               redirect_valid_o;
  logic [MXLEN-1:0]   redirect_pc_o;
  logic [1:0]         priv_o;
  logic               busy_o;

  modport master (
    output exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_valid_i,
           int_pending_i, int_pc_i, mstatus_i, mtvec_i, mepc_i,
    input  exc_ready_o, csr_we_o, csr_addr_o, csr_wdata_o, flush_o,
           redirect_valid_o, redirect_pc_o, priv_o, busy_o
  );

  modport slave (
    input  exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_valid_i,
           int_pending_i, int_pc_i, mstatus_i, mtvec_i, mepc_i,
    output exc_ready_o, csr_we_o, csr_addr_o, csr_wdata_o, flush_o,
           redirect_valid_o, redirect_pc_o, priv_o, busy_o
  );
endinterface

// File: rtl/trap_sequencer.sv
// M-mode trap entry/return: 4 CSR writes + redirect (trap) or 1 write + redirect (mret).
// Requests are accepted only in IDLE; a pending interrupt holds off exceptions and mret.
module trap_sequencer #(
  parameter int MXLEN   = 64,
  parameter int NUM_INT = 14
) (
  input  logic            clk_i,
  input  logic            rst_i,
  trap_sequencer_if.slave bus
);
  localparam logic [1:0]  PRIV_M       = 2'b11;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam int          MIE_B        = 3;
  localparam int          MPIE_B       = 7;
  localparam int          MPRV_B       = 17;
  localparam int          PW           = (NUM_INT > 14) ? NUM_INT : 14;

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, REDIRECT, R_MSTATUS, R_REDIRECT
  } state_t;

  state_t           state_q;
  logic [1:0]       priv_q;
  logic             intr_q;
  logic [5:0]       code_q;
  logic [MXLEN-1:0] tval_q, mstatus_q, mtvec_q, mepc_q;
  logic             csr_we_q, flush_q, redir_vld_q;
  logic [11:0]      csr_addr_q;
  logic [MXLEN-1:0] csr_wdata_q, redir_pc_q;

  logic [PW-1:0]    pend_d;
  logic [5:0]       int_code_d;
  logic             int_take_d;
  logic [MXLEN-1:0] sel_pc_d, mcause_d, trap_target_d;

  function automatic logic [MXLEN-1:0] trap_mstatus(input logic [MXLEN-1:0] m, input logic [1:0] p);
    trap_mstatus          = m;
    trap_mstatus[MPIE_B]  = m[MIE_B];
    trap_mstatus[MIE_B]   = 1'b0;
    trap_mstatus[12:11]   = p;
  endfunction

  function automatic logic [MXLEN-1:0] ret_mstatus(input logic [MXLEN-1:0] m);
    ret_mstatus          = m;
    ret_mstatus[MIE_B]   = m[MPIE_B];
    ret_mstatus[MPIE_B]  = 1'b1;
    ret_mstatus[12:11]   = 2'b00;
    if (m[12:11] != PRIV_M) ret_mstatus[MPRV_B] = 1'b0;
  endfunction

  assign pend_d     = PW'(bus.int_pending_i);
  assign int_take_d = (|bus.int_pending_i) && (bus.mstatus_i[MIE_B] || priv_q != PRIV_M);
  assign sel_pc_d   = int_take_d ? bus.int_pc_i : bus.exc_pc_i;
  assign mcause_d   = {intr_q, {(MXLEN-7){1'b0}}, code_q};

  // Later assignments win, so the preferred order 11,3,7,9,1,5,13 is applied last-to-first.
  always_comb begin
    int_code_d = '0;
    for (int i = PW-1; i >= 0; i--)
      if (pend_d[i]) int_code_d = 6'(i);
    if (pend_d[13]) int_code_d = 6'd13;
    if (pend_d[5])  int_code_d = 6'd5;
    if (pend_d[1])  int_code_d = 6'd1;
    if (pend_d[9])  int_code_d = 6'd9;
    if (pend_d[7])  int_code_d = 6'd7;
    if (pend_d[3])  int_code_d = 6'd3;
    if (pend_d[11]) int_code_d = 6'd11;
  end

  always_comb begin
    trap_target_d = {mtvec_q[MXLEN-1:2], 2'b00};
    if (mtvec_q[1:0] == 2'b01 && intr_q)
      trap_target_d = trap_target_d + MXLEN'({code_q, 2'b00});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      priv_q      <= PRIV_M;
      intr_q      <= 1'b0;
      code_q      <= '0;
      tval_q      <= '0;
      mstatus_q   <= '0;
      mtvec_q     <= '0;
      mepc_q      <= '0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      flush_q     <= 1'b0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (int_take_d || bus.exc_valid_i || bus.mret_valid_i) begin
            mstatus_q <= bus.mstatus_i;
            mtvec_q   <= bus.mtvec_i;
            mepc_q    <= bus.mepc_i;
            intr_q    <= int_take_d;
            code_q    <= int_take_d ? int_code_d : bus.exc_cause_i;
            tval_q    <= (!int_take_d && bus.exc_valid_i) ? bus.exc_tval_i : '0;
            flush_q   <= 1'b1;
            csr_we_q  <= 1'b1;
            if (int_take_d || bus.exc_valid_i) begin
              state_q     <= W_MEPC;
              csr_addr_q  <= CSR_MEPC;
              csr_wdata_q <= {sel_pc_d[MXLEN-1:1], 1'b0};
            end else begin
              state_q     <= R_MSTATUS;
              csr_addr_q  <= CSR_MSTATUS;
              csr_wdata_q <= ret_mstatus(bus.mstatus_i);
            end
          end
        end
        W_MEPC: begin
          state_q     <= W_MCAUSE;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= CSR_MCAUSE;
          csr_wdata_q <= mcause_d;
        end
        W_MCAUSE: begin
          state_q     <= W_MTVAL;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= CSR_MTVAL;
          csr_wdata_q <= tval_q;
        end
        W_MTVAL: begin
          state_q     <= W_MSTATUS;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= CSR_MSTATUS;
          csr_wdata_q <= trap_mstatus(mstatus_q, priv_q);
        end
        W_MSTATUS: begin
          state_q     <= REDIRECT;
          redir_vld_q <= 1'b1;
          redir_pc_q  <= trap_target_d;
        end
        REDIRECT: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
          priv_q  <= PRIV_M;
        end
        R_MSTATUS: begin
          state_q     <= R_REDIRECT;
          redir_vld_q <= 1'b1;
          redir_pc_q  <= {mepc_q[MXLEN-1:1], 1'b0};
        end
        R_REDIRECT: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
          priv_q  <= (mstatus_q[12:11] == 2'b10) ? 2'b00 : mstatus_q[12:11];
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.exc_ready_o      = (state_q == IDLE) && !int_take_d;
  assign bus.csr_we_o         = csr_we_q;
  assign bus.csr_addr_o       = csr_addr_q;
  assign bus.csr_wdata_o      = csr_wdata_q;
  assign bus.flush_o          = flush_q;
  assign bus.redirect_valid_o = redir_vld_q;
  assign bus.redirect_pc_o    = redir_pc_q;
  assign bus.priv_o           = priv_q;
  assign bus.busy_o           = (state_q != IDLE);
endmodule
